// File: rtl/frame_serializer.sv
// frame_serializer
//   Feeds the serial pattern detector with a continuous, frame-aligned bit
//   stream. Parallel frames arrive over a valid/ready handshake and wait in a
//   small FIFO. They are shifted out MSB-first, one bit per clock. When no
//   frame is queued at a frame boundary, FILL_WORD is sent instead, so the
//   detector's frame phase never slips.
//
// Handshake (valid/ready): a word transfers on a rising edge where
//   in_valid & in_ready are both high. in_ready depends only on registered
//   state, never on in_valid. While in_valid is high and in_ready is low, the
//   source holds in_word stable until the transfer happens.
//
// Ports
//   clk          rising-edge clock; data_out launches on posedge
//   reset        asynchronous, active-low
//   in_word      parallel frame, MSB transmitted first
//   in_valid     in_word valid this cycle
//   in_ready     FIFO can accept a word
//   data_out     serial bit to the detector
//   frame_start  high while data_out carries the MSB of a frame
//   fill_active  high for every bit of an inserted FILL_WORD frame
//   fill_count   saturating count of inserted FILL frames
//   state_dbg    FSM state (0 = START, 1 = SHIFT), for checkers
module frame_serializer #(
  parameter int                    FRAME_BITS = 4,
  parameter int                    DEPTH      = 2,
  parameter logic [FRAME_BITS-1:0] FILL_WORD  = '0,
  parameter int                    CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [FRAME_BITS-1:0] in_word,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  data_out,
  output logic                  frame_start,
  output logic                  fill_active,
  output logic [CNT_W-1:0]      fill_count,
  output logic                  state_dbg
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

  typedef enum logic {START = 1'b0, SHIFT = 1'b1} state_t;

  state_t                  state_q;
  logic [BW-1:0]           bit_cnt_q;
  logic [FRAME_BITS-1:0]   sr_q;
  logic                    frame_start_q;
  logic                    fill_active_q;
  logic [CNT_W-1:0]        fill_count_q;

  logic [FRAME_BITS-1:0]   mem_q [DEPTH];
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [AW:0]             count_q, count_d;

  logic full, empty, push, pop, load;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);

  // in_ready stays low through reset and the START edge, then tracks !full.
  assign in_ready = (state_q == SHIFT) && !full;
  assign push     = in_valid && in_ready;

  // The START edge and every counter wrap load a fresh frame.
  assign load = (state_q == START) || (bit_cnt_q == BW'(FRAME_BITS - 1));
  // Pop uses pre-edge occupancy, so a word pushed on this edge is never
  // bypassed into the frame being loaded now.
  assign pop  = load && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_word;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= START;
      bit_cnt_q     <= '0;
      sr_q          <= '0;
      frame_start_q <= 1'b0;
      fill_active_q <= 1'b0;
      fill_count_q  <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      state_q  <= SHIFT;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (load) begin
        bit_cnt_q     <= '0;
        frame_start_q <= 1'b1;
        if (!empty) begin
          sr_q          <= mem_q[rd_ptr_q];
          fill_active_q <= 1'b0;
        end else begin
          sr_q          <= FILL_WORD;
          fill_active_q <= 1'b1;
          if (fill_count_q != '1) fill_count_q <= fill_count_q + 1'b1;
        end
      end else begin
        bit_cnt_q     <= bit_cnt_q + 1'b1;
        sr_q          <= {sr_q[FRAME_BITS-2:0], 1'b0};
        frame_start_q <= 1'b0;
      end
    end
  end

  // data_out comes straight from the shift register MSB, so it is registered.
  assign data_out    = sr_q[FRAME_BITS-1];
  assign frame_start = frame_start_q;
  assign fill_active = fill_active_q;
  assign fill_count  = fill_count_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_frame_serializer.sv
// Testbench for frame_serializer. A queue-based reference model tracks the
// frame phase, the queued words and the fill counter. Each test compares the
// DUT against this model on every negedge. Each test also makes its own
// scenario checks against fixed constants.
module tb_frame_serializer;
  localparam int FB    = 4;
  localparam int DEPTH = 2;
  localparam int CNT_W = 8;
  localparam int SAT   = (1 << CNT_W) - 1;
  localparam logic [FB-1:0] FILL = 4'b0000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [FB-1:0] in_word = '0;
  logic in_valid = 1'b0;
  logic in_ready, data_out, frame_start, fill_active, state_dbg;
  logic [CNT_W-1:0] fill_count;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  frame_serializer #(.FRAME_BITS(FB), .DEPTH(DEPTH), .FILL_WORD(FILL), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_word(in_word), .in_valid(in_valid),
    .in_ready(in_ready), .data_out(data_out), .frame_start(frame_start),
    .fill_active(fill_active), .fill_count(fill_count), .state_dbg(state_dbg)
  );

  // ---------------- reference model ----------------
  logic [FB-1:0] exp_q[$];
  bit            m_started;
  int            m_phase;
  logic [FB-1:0] m_cur;
  bit            m_fill;
  int            m_fcnt;

  function automatic void m_reset();
    exp_q.delete();
    m_started = 0;
    m_phase   = 0;
    m_cur     = '0;
    m_fill    = 0;
    m_fcnt    = 0;
  endfunction

  function automatic void m_load();
    m_phase = 0;
    if (exp_q.size() > 0) begin
      m_cur  = exp_q.pop_front();
      m_fill = 0;
    end else begin
      m_cur  = FILL;
      m_fill = 1;
      if (m_fcnt < SAT) m_fcnt++;
    end
  endfunction

  function automatic bit m_ready();
    return m_started && (exp_q.size() < DEPTH);
  endfunction

  function automatic logic [11:0] exp_vec();
    logic d;
    d = m_started ? m_cur[FB-1-m_phase] : 1'b0;
    return {m_ready(), d, (m_started && m_phase == 0), m_fill, CNT_W'(m_fcnt)};
  endfunction

  function automatic logic [11:0] got_vec();
    return {in_ready, data_out, frame_start, fill_active, fill_count};
  endfunction

  // One clock: decide acceptance from pre-edge state, step the model at the
  // edge (load before push, so no bypass), and return at the next negedge.
  task automatic tick(output bit acc);
    acc = in_valid && m_ready();
    @(posedge clk);
    if (!m_started) begin
      m_started = 1;
      m_load();
    end else if (m_phase == FB - 1) begin
      m_load();
    end else begin
      m_phase++;
    end
    if (acc) exp_q.push_back(in_word);
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bit acc;
    reset = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    tests_run++;
    if (got_vec() !== 12'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs got=%b exp=%b", got_vec(), 12'd0);
    end
    reset = 1'b1;
    tick(acc);
    tests_run++;
    if ({frame_start, fill_active, fill_count} !== {1'b1, 1'b1, 8'd1}) begin
      tests_failed++;
      $display("FAIL reset_first_frame got=%b exp=%b", {frame_start, fill_active, fill_count}, {1'b1, 1'b1, 8'd1});
    end
  endtask

  task automatic test_single();
    bit acc;
    int lat;
    logic [FB-1:0] bits;
    bit extra_fs;
    in_valid = 1'b1;
    in_word  = 4'b1001;
    tick(acc);
    in_valid = 1'b0;
    tests_run++;
    if (acc !== 1'b1 || got_vec() !== exp_vec()) begin
      tests_failed++;
      $display("FAIL single_accept got=%b exp=%b", got_vec(), exp_vec());
    end
    lat = 0;
    while (!(frame_start && !fill_active) && lat < 8) begin
      tick(acc);
      lat++;
      tests_run++;
      if (got_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL single_stream got=%b exp=%b", got_vec(), exp_vec());
      end
    end
    tests_run++;
    if (lat < 1 || lat > FB) begin
      tests_failed++;
      $display("FAIL single_latency got=%0d exp=1..%0d", lat, FB);
    end
    bits = '0;
    bits[FB-1] = data_out;
    extra_fs = 0;
    for (int i = 1; i < FB; i++) begin
      tick(acc);
      bits[FB-1-i] = data_out;
      if (frame_start) extra_fs = 1;
    end
    tests_run++;
    if (bits !== 4'b1001 || extra_fs) begin
      tests_failed++;
      $display("FAIL single_bits got=%b fs_extra=%0d exp=1001 fs_extra=0", bits, extra_fs);
    end
  endtask

  task automatic test_back_to_back();
    bit acc;
    bit saw_not_ready;
    bit collecting;
    bit fill_seen;
    int guard;
    logic [FB-1:0] words[3];
    bit obs[$];
    logic [11:0] packed_obs;
    words[0] = 4'b0101; words[1] = 4'b1001; words[2] = 4'b0011;
    // Align so the first push lands right after a load edge.
    guard = 0;
    while (!(m_phase == 0 && exp_q.size() == 0) && guard < 20) begin
      tick(acc);
      guard++;
    end
    saw_not_ready = 0;
    collecting = 0;
    fill_seen = 0;
    for (int w = 0; w < 3; w++) begin
      in_valid = 1'b1;
      in_word  = words[w];
      acc = 0;
      guard = 0;
      while (!acc && guard < 20) begin
        if (!in_ready) saw_not_ready = 1;
        tick(acc);
        guard++;
        tests_run++;
        if (got_vec() !== exp_vec()) begin
          tests_failed++;
          $display("FAIL b2b_stream got=%b exp=%b", got_vec(), exp_vec());
        end
        if (frame_start && !fill_active) collecting = 1;
        if (collecting && obs.size() < 12) begin
          obs.push_back(data_out);
          if (fill_active) fill_seen = 1;
        end
      end
    end
    in_valid = 1'b0;
    guard = 0;
    while (obs.size() < 12 && guard < 40) begin
      tick(acc);
      guard++;
      tests_run++;
      if (got_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL b2b_stream got=%b exp=%b", got_vec(), exp_vec());
      end
      if (frame_start && !fill_active) collecting = 1;
      if (collecting) begin
        obs.push_back(data_out);
        if (fill_active) fill_seen = 1;
      end
    end
    packed_obs = '0;
    foreach (obs[i]) if (i < 12) packed_obs[11-i] = obs[i];
    tests_run++;
    if (obs.size() != 12 || packed_obs !== 12'b0101_1001_0011 || fill_seen) begin
      tests_failed++;
      $display("FAIL b2b_order got=%b fill=%0d exp=010110010011 fill=0", packed_obs, fill_seen);
    end
    tests_run++;
    if (!saw_not_ready) begin
      tests_failed++;
      $display("FAIL b2b_ready_drop got=never_low exp=low_when_full");
    end
  endtask

  task automatic test_underrun();
    bit acc;
    int guard, fs_cnt, exp_cnt;
    bit all_fill, any_one;
    logic [11:0] fs_mask;
    in_valid = 1'b0;
    guard = 0;
    while (!(exp_q.size() == 0 && m_fill == 0 && m_phase == FB - 1) && guard < 40) begin
      tick(acc);
      guard++;
    end
    exp_cnt = (m_fcnt + 3 > SAT) ? SAT : m_fcnt + 3;
    fs_cnt = 0; all_fill = 1; any_one = 0; fs_mask = '0;
    for (int i = 0; i < 12; i++) begin
      tick(acc);
      tests_run++;
      if (got_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL underrun_stream got=%b exp=%b", got_vec(), exp_vec());
      end
      fs_mask[11-i] = frame_start;
      if (frame_start) fs_cnt++;
      if (!fill_active) all_fill = 0;
      if (data_out) any_one = 1;
    end
    tests_run++;
    if (fs_mask !== 12'b1000_1000_1000 || fs_cnt != 3 || !all_fill || any_one) begin
      tests_failed++;
      $display("FAIL underrun_frames got=fs%b fill=%0d one=%0d exp=fs100010001000 fill=1 one=0", fs_mask, all_fill, any_one);
    end
    tests_run++;
    if (fill_count !== CNT_W'(exp_cnt)) begin
      tests_failed++;
      $display("FAIL underrun_count got=%0d exp=%0d", fill_count, exp_cnt);
    end
  endtask

  task automatic test_random();
    bit acc;
    acc = 1;
    for (int i = 0; i < 400; i++) begin
      // Source holds word/valid until accepted.
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_word  = FB'($urandom);
      end
      tick(acc);
      tests_run++;
      if (got_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL random_stream cyc=%0d got=%b exp=%b", i, got_vec(), exp_vec());
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_async_reset_bit2();
    bit acc;
    int guard;
    in_valid = 1'b1;
    in_word  = 4'b1111;
    guard = 0;
    while (!(m_phase == 2 && exp_q.size() > 0) && guard < 40) begin
      tick(acc);
      guard++;
    end
    in_valid = 1'b0;
    tests_run++;
    if (!(m_phase == 2 && exp_q.size() > 0)) begin
      tests_failed++;
      $display("FAIL async_setup got=phase%0d q%0d exp=phase2 q>0", m_phase, exp_q.size());
    end
    #2 reset = 1'b0;
    #1;
    tests_run++;
    if (got_vec() !== 12'd0) begin
      tests_failed++;
      $display("FAIL async_reset_outputs got=%b exp=%b", got_vec(), 12'd0);
    end
    m_reset();
    @(negedge clk);
    reset = 1'b1;
    tick(acc);
    tests_run++;
    if ({frame_start, fill_active, fill_count, data_out} !== {1'b1, 1'b1, 8'd1, 1'b0}) begin
      tests_failed++;
      $display("FAIL async_fresh_frame got=%b exp=%b", {frame_start, fill_active, fill_count, data_out}, {1'b1, 1'b1, 8'd1, 1'b0});
    end
    for (int i = 0; i < 8; i++) begin
      tick(acc);
      tests_run++;
      if (got_vec() !== exp_vec() || fill_active !== 1'b1) begin
        tests_failed++;
        $display("FAIL async_queue_gone got=%b exp=%b", got_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_saturation();
    bit acc;
    in_valid = 1'b0;
    for (int i = 0; i < 300 * FB; i++) begin
      tick(acc);
      tests_run++;
      if (got_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL sat_stream cyc=%0d got=%b exp=%b", i, got_vec(), exp_vec());
      end
    end
    tests_run++;
    if (fill_count !== 8'd255) begin
      tests_failed++;
      $display("FAIL sat_count got=%0d exp=255", fill_count);
    end
  endtask

  task automatic test_reset_full();
    bit acc;
    int guard;
    in_valid = 1'b1;
    guard = 0;
    while (m_ready() && guard < 20) begin
      in_word = FB'($urandom);
      tick(acc);
      guard++;
    end
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_ready got=%b exp=0", in_ready);
    end
    #3 reset = 1'b0;
    #1;
    in_valid = 1'b0;
    tests_run++;
    if (got_vec() !== 12'd0) begin
      tests_failed++;
      $display("FAIL full_reset_outputs got=%b exp=%b", got_vec(), 12'd0);
    end
    m_reset();
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (got_vec() !== 12'd0) begin
      tests_failed++;
      $display("FAIL full_reset_hold got=%b exp=%b", got_vec(), 12'd0);
    end
    reset = 1'b1;
    tick(acc);
    tests_run++;
    if ({frame_start, fill_active, fill_count} !== {1'b1, 1'b1, 8'd1}) begin
      tests_failed++;
      $display("FAIL full_first_frame got=%b exp=%b", {frame_start, fill_active, fill_count}, {1'b1, 1'b1, 8'd1});
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_underrun();
    test_random();
    test_async_reset_bit2();
    test_saturation();
    test_reset_full();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
